// File: rtl/ysyx_wbu.sv
// Writeback/commit stage: buffers execute results in order, retires one per cycle,
// and redirects or halts as needed. Define YSYX_WBU_TRACE_EN for a per-retire trace line.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_wbu #(
  parameter int BIT_W = `YSYX_W_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prev_valid,
  output logic             ready_o,
  input  logic [31:0]      inst,
  input  logic [BIT_W-1:0] pc,
  input  logic [BIT_W-1:0] reg_wdata,
  input  logic [3:0]       rd,
  input  logic [BIT_W-1:0] npc_wdata,
  input  logic             use_exu_npc,
  input  logic             speculation,
  input  logic             ebreak,
  output logic             rf_wen_o,
  output logic [3:0]       rf_waddr_o,
  output logic [BIT_W-1:0] rf_wdata_o,
  output logic             redirect_o,
  output logic [BIT_W-1:0] redirect_pc_o,
  output logic             flush_o,
  output logic             retire_o,
  output logic [BIT_W-1:0] retire_pc_o,
  output logic [31:0]      retire_inst_o,
  output logic             halt_o,
  output logic [63:0]      instret_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]      inst;
    logic [BIT_W-1:0] pc;
    logic [BIT_W-1:0] reg_wdata;
    logic [3:0]       rd;
    logic [BIT_W-1:0] npc;
    logic             use_npc;
    logic             spec;
    logic             ebreak;
  } entry_t;

  typedef enum logic {RUN, HALT} state_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  state_t           state;
  logic [63:0]      instret;

  entry_t head_e;
  logic   running;
  logic   occupied;
  logic   retire;
  logic   skip;
  logic   flush;
  logic   accept;
  logic   pop;

  assign head_e   = mem[head];
  assign running  = (state == RUN);
  assign occupied = (count != '0);
  // A flushed entry still occupies its slot until the head walks past it.
  assign retire   = running && occupied && live[head];
  assign skip     = running && occupied && !live[head];
  assign flush    = retire && head_e.use_npc;
  assign pop      = retire || skip;
  assign ready_o  = running && (count < FULL);
  assign accept   = prev_valid && ready_o && !(flush && speculation);

  assign retire_o      = retire;
  assign retire_pc_o   = retire ? head_e.pc : '0;
  assign retire_inst_o = retire ? head_e.inst : '0;
  assign rf_wen_o      = retire && (head_e.rd != 4'd0);
  assign rf_waddr_o    = retire ? head_e.rd : 4'd0;
  assign rf_wdata_o    = rf_wen_o ? head_e.reg_wdata : '0;
  assign redirect_o    = flush;
  assign redirect_pc_o = flush ? head_e.npc : '0;
  assign flush_o       = flush;
  assign halt_o        = (state == HALT);
  assign instret_o     = instret;

  // Payload storage carries no reset; occupancy is tracked by live/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[tail] <= '{inst: inst, pc: pc, reg_wdata: reg_wdata, rd: rd, npc: npc_wdata,
                     use_npc: use_exu_npc, spec: speculation, ebreak: ebreak};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      live    <= '0;
      state   <= RUN;
      instret <= '0;
    end else begin
      // Everything behind the redirecting head is younger; drop its speculative work.
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if ((PW'(i) != head) && mem[i].spec) live[i] <= 1'b0;
        end
      end
      if (accept) begin
        live[tail] <= 1'b1;
        tail       <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
      if (retire) instret <= instret + 64'd1;
      if (retire && head_e.ebreak) state <= HALT;
    end
  end

`ifdef YSYX_WBU_TRACE_EN
  always @(posedge clk) begin
    if (rst && retire) begin
      $write("[wbu] pc=%h inst=%h", head_e.pc, head_e.inst);
      if (rf_wen_o) $write(" x%0d=%h", head_e.rd, head_e.reg_wdata);
      if (redirect_o) $write(" redirect %h", head_e.npc);
      if (head_e.ebreak) $write(" HALT");
      $display("");
    end
  end
`else
  // Trace output compiled out.
`endif

endmodule

// File: tb/tb_ysyx_wbu.sv
// Bench for ysyx_wbu: directed checks pinned to literals, then random traffic
// compared every cycle against an in-order queue model.
module tb_ysyx_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        prev_valid;
  logic        ready_o;
  logic [31:0] inst, pc, reg_wdata, npc_wdata;
  logic [3:0]  rd;
  logic        use_exu_npc, speculation, ebreak;
  logic        rf_wen_o;
  logic [3:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic        retire_o;
  logic [31:0] retire_pc_o;
  logic [31:0] retire_inst_o;
  logic        halt_o;
  logic [63:0] instret_o;

  ysyx_wbu #(.BIT_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o),
    .inst(inst), .pc(pc), .reg_wdata(reg_wdata), .rd(rd), .npc_wdata(npc_wdata),
    .use_exu_npc(use_exu_npc), .speculation(speculation), .ebreak(ebreak),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .flush_o(flush_o),
    .retire_o(retire_o), .retire_pc_o(retire_pc_o), .retire_inst_o(retire_inst_o),
    .halt_o(halt_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst, pc, wdata, npc;
    logic [3:0]  rd;
    logic        use_npc, spec, ebrk, live;
  } mentry_t;

  mentry_t     mq[$];
  bit          halted;
  logic [63:0] minstret;
  int          checks;
  int          errors;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs follow from the model queue: the oldest live entry retires.
  task automatic compareAll();
    mentry_t h;
    bit      r;
    h = '{default: '0};
    r = !halted && mq.size() > 0 && mq[0].live;
    if (r) h = mq[0];
    checkOutput("ready", ready_o, !halted && mq.size() < 2);
    checkOutput("retire", retire_o, r);
    checkOutput("retire_pc", retire_pc_o, r ? h.pc : 32'd0);
    checkOutput("retire_inst", retire_inst_o, r ? h.inst : 32'd0);
    checkOutput("rf_wen", rf_wen_o, r && h.rd != 0);
    checkOutput("rf_waddr", rf_waddr_o, r ? h.rd : 4'd0);
    checkOutput("rf_wdata", rf_wdata_o, (r && h.rd != 0) ? h.wdata : 32'd0);
    checkOutput("redirect", redirect_o, r && h.use_npc);
    checkOutput("redirect_pc", redirect_pc_o, (r && h.use_npc) ? h.npc : 32'd0);
    checkOutput("flush", flush_o, r && h.use_npc);
    checkOutput("halt", halt_o, halted);
    checkOutput("instret", instret_o, minstret);
  endtask

  // Advances the model across the coming clock edge using the inputs now applied.
  task automatic commitModel();
    bit rdy, r, fl;
    mentry_t e;
    if (!rst) begin
      mq.delete();
      halted   = 0;
      minstret = 0;
      return;
    end
    rdy = !halted && mq.size() < 2;
    r   = !halted && mq.size() > 0 && mq[0].live;
    fl  = r && mq[0].use_npc;
    if (r) begin
      if (mq[0].ebrk) halted = 1;
      void'(mq.pop_front());
      minstret++;
      if (fl) foreach (mq[i]) if (mq[i].spec) mq[i].live = 0;
    end else if (!halted && mq.size() > 0) begin
      void'(mq.pop_front());
    end
    if (prev_valid && rdy && !(fl && speculation)) begin
      e = '{inst: inst, pc: pc, wdata: reg_wdata, npc: npc_wdata, rd: rd,
            use_npc: use_exu_npc, spec: speculation, ebrk: ebreak, live: 1'b1};
      mq.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] w, input logic [3:0] d, input logic [31:0] n,
                               input logic u, input logic s, input logic e);
    @(negedge clk);
    rst = r; prev_valid = v; inst = i; pc = p; reg_wdata = w; rd = d;
    npc_wdata = n; use_exu_npc = u; speculation = s; ebreak = e;
    #1;
    compareAll();
  endtask

  task automatic idle(input logic r);
    applyStimulus(r, 1'b0, 32'd0, 32'd0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  int halt_wait;

  initial begin
    checks = 0; errors = 0; halted = 0; minstret = 0;
    rst = 1'b0; prev_valid = 1'b0; inst = '0; pc = '0; reg_wdata = '0; rd = '0;
    npc_wdata = '0; use_exu_npc = 1'b0; speculation = 1'b0; ebreak = 1'b0;

    // Reset state
    idle(1'b0); commitModel();
    idle(1'b1);
    checkOutput("lit_reset_ready", ready_o, 1);
    checkOutput("lit_reset_instret", instret_o, 0);
    commitModel();

    // Single ALU op
    applyStimulus(1, 1, 32'h00500293, 32'h80000000, 32'h1234, 4'd5, 0, 0, 0, 0); commitModel();
    idle(1'b1);
    checkOutput("lit_alu_retire", retire_o, 1);
    checkOutput("lit_alu_wen", rf_wen_o, 1);
    checkOutput("lit_alu_waddr", rf_waddr_o, 5);
    checkOutput("lit_alu_wdata", rf_wdata_o, 32'h1234);
    checkOutput("lit_alu_pc", retire_pc_o, 32'h80000000);
    commitModel();
    idle(1'b1);
    checkOutput("lit_alu_instret", instret_o, 1);
    commitModel();

    // Write to x0
    applyStimulus(1, 1, 32'h00000013, 32'h80000004, 32'hdead, 4'd0, 0, 0, 0, 0); commitModel();
    idle(1'b1);
    checkOutput("lit_x0_retire", retire_o, 1);
    checkOutput("lit_x0_wen", rf_wen_o, 0);
    checkOutput("lit_x0_wdata", rf_wdata_o, 0);
    commitModel();

    // Redirect: speculative follower arriving in the flush cycle is dropped
    applyStimulus(1, 1, 32'h0000006f, 32'h80000010, 0, 4'd0, 32'h80000100, 1, 0, 0); commitModel();
    applyStimulus(1, 1, 32'h00100093, 32'h80000014, 32'h7, 4'd1, 0, 0, 1, 0);
    checkOutput("lit_redir", redirect_o, 1);
    checkOutput("lit_redir_pc", redirect_pc_o, 32'h80000100);
    checkOutput("lit_redir_flush", flush_o, 1);
    commitModel();
    idle(1'b1);
    checkOutput("lit_redir_noretire", retire_o, 0);
    checkOutput("lit_redir_instret", instret_o, 3);
    commitModel();

    // Ebreak halts; later traffic is ignored until reset
    applyStimulus(1, 1, 32'h00100073, 32'h80000040, 0, 4'd0, 0, 0, 0, 1); commitModel();
    applyStimulus(1, 1, 32'h00000013, 32'h80000044, 0, 4'd2, 0, 0, 0, 0);
    checkOutput("lit_ebreak_retire", retire_o, 1);
    checkOutput("lit_ebreak_pc", retire_pc_o, 32'h80000040);
    commitModel();
    applyStimulus(1, 1, 32'h00000013, 32'h80000048, 0, 4'd3, 0, 0, 0, 0);
    checkOutput("lit_halt", halt_o, 1);
    checkOutput("lit_halt_ready", ready_o, 0);
    checkOutput("lit_halt_noretire", retire_o, 0);
    commitModel();
    idle(1'b1); commitModel();
    idle(1'b0); commitModel();
    idle(1'b1);
    checkOutput("lit_unhalt", halt_o, 0);
    checkOutput("lit_unhalt_instret", instret_o, 0);
    commitModel();

    // Reset mid-operation
    applyStimulus(1, 1, 32'h00000013, 32'h80000050, 32'h11, 4'd6, 0, 0, 0, 0); commitModel();
    applyStimulus(0, 1, 32'h00000013, 32'h80000054, 32'h22, 4'd7, 0, 0, 0, 0); commitModel();
    idle(1'b1);
    checkOutput("lit_midrst_retire", retire_o, 0);
    checkOutput("lit_midrst_wen", rf_wen_o, 0);
    checkOutput("lit_midrst_instret", instret_o, 0);
    commitModel();

    // Random traffic
    halt_wait = 0;
    for (int c = 0; c < 3000; c++) begin
      logic r;
      halt_wait = halted ? halt_wait + 1 : 0;
      r = !(($urandom_range(0, 299) == 0) || (halt_wait > 3));
      applyStimulus(r, $urandom_range(0, 9) < 7, $urandom, $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 9) < 2,
                    $urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0);
      commitModel();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
